// File: rtl/ram_1w1r_masked.sv
// ram_1w1r_masked: single-clock 1W/1R RAM with lane write mask, post-reset clear and read-valid strobe.
// Define RAM_BYPASS_EN to forward same-cycle same-address write data to the read port.
`timescale 1ns/1ps
module ram_1w1r_masked #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   busy
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Port protocol: a request is taken on any posedge where its csb is low and
  // busy is low. There is no backpressure; requests seen while busy are dropped.
  // dout1_valid is high for exactly the cycle after each accepted read.

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (clr_ptr == LAST_ADDR) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (state == INIT) begin
      clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
    end
  end

  assign busy  = (state == INIT);
  assign wr_en = (state == READY) && !csb0;
  assign rd_en = (state == READY) && !csb1;

  // Array has no reset; the clear walk owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[addr1];
`ifdef RAM_BYPASS_EN
    if (wr_en && (addr0 == addr1)) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask0[i]) begin
          rd_word[i*LANE_WIDTH +: LANE_WIDTH] = din0[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1       <= '0;
      dout1_valid <= 1'b0;
    end else begin
      dout1_valid <= rd_en;
      if (rd_en) begin
        dout1 <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_1w1r_masked.sv
// Bench for ram_1w1r_masked: vector table plus hand sequences, checked by a queue scoreboard.
// Honours RAM_BYPASS_EN for the collision expectation.
`timescale 1ns/1ps
module tb_ram_1w1r_masked;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int MW    = 2;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst;
  logic          csb0;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;
  logic          dout1_valid;
  logic          busy;

  ram_1w1r_masked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1),
    .dout1(dout1), .dout1_valid(dout1_valid), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];
  logic [DW-1:0] last_exp = '0;
  int            total = 0;
  int            bad = 0;
  int            valid_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] e);
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (dout1_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got dout1_valid=1 data %0h expected no read (cycle %0d)", dout1, cyc);
      end else begin
        logic [DW-1:0] e;
        int            c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("read_data", 32'(dout1), 32'(e));
        check("read_latency", 32'(cyc), 32'(c));
        last_exp = e;
      end
    end else begin
      check("dout_hold", 32'(dout1), 32'(last_exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [MW-1:0] wm, input bit re, input logic [AW-1:0] ra);
    @(negedge clk);
    csb0   = !we;
    addr0  = wa;
    din0   = wd;
    wmask0 = wm;
    csb1   = !re;
    addr1  = ra;
  endtask

  task automatic set_idle();
    csb0   = 1'b1;
    csb1   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    addr1  = '0;
  endtask

  task automatic drain();
    repeat (3) drive(0, '0, '0, '0, 0, '0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Called at a negedge; checks the asynchronous effect right away.
  task automatic assert_rst();
    rst = 1'b1;
    set_idle();
    #1;
    check("rst_dout1", 32'(dout1), 32'd0);
    check("rst_valid", 32'(dout1_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    exp_q.delete();
    cyc_q.delete();
    last_exp = '0;
  endtask

  // Releases reset at a negedge and counts posedges spent busy. With poke set,
  // a write of 0xBEEF to 0x05 and a read of 0x05 are held for the whole clear.
  task automatic release_rst(input bit poke);
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    if (poke) begin
      csb0 = 1'b0; wmask0 = 2'b11; addr0 = 8'h05; din0 = 16'hBEEF;
      csb1 = 1'b0; addr1 = 8'h05;
    end
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    set_idle();
    check("busy_cycles", 32'(n), 32'(DEPTH));
  endtask

  task automatic sweep_zero();
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, '0, '0, '0, 1, AW'(a));
      push('0);
    end
    drain();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    bit            re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[11];

`ifdef RAM_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = 16'h12FF;
`else
  localparam logic [DW-1:0] COLL_EXP = 16'h1234;
`endif

  initial begin
    vecs[0]  = '{1, 8'h10, 16'hAAAA, 2'b11, 0, 8'h00, 16'h0000};
    vecs[1]  = '{1, 8'h10, 16'h5555, 2'b01, 0, 8'h00, 16'h0000};
    vecs[2]  = '{0, 8'h00, 16'h0000, 2'b00, 1, 8'h10, 16'hAA55};
    vecs[3]  = '{1, 8'h10, 16'hFFFF, 2'b00, 1, 8'h00, 16'h0000};
    vecs[4]  = '{0, 8'h00, 16'h0000, 2'b00, 1, 8'h10, 16'hAA55};
    vecs[5]  = '{1, 8'h00, 16'h1357, 2'b10, 1, 8'h10, 16'hAA55};
    vecs[6]  = '{0, 8'h00, 16'h0000, 2'b00, 1, 8'h00, 16'h1300};
    vecs[7]  = '{1, 8'hFF, 16'hC0DE, 2'b11, 0, 8'h00, 16'h0000};
    vecs[8]  = '{1, 8'h10, 16'h0F0F, 2'b10, 1, 8'hFF, 16'hC0DE};
    vecs[9]  = '{0, 8'h00, 16'h0000, 2'b00, 1, 8'h10, 16'h0F55};
    vecs[10] = '{0, 8'h00, 16'h0000, 2'b00, 1, 8'hFF, 16'hC0DE};

    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);

    // Reset values, clear length, and requests dropped during the clear.
    assert_rst();
    release_rst(1);
    drive(0, '0, '0, '0, 1, 8'h05);
    push('0);
    drain();
    sweep_zero();

    // Table: masked writes, no-op mask, top address, independent ports.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].re, vecs[i].ra);
      if (vecs[i].re) push(vecs[i].exp);
    end
    drain();

    // Streaming: back-to-back writes then back-to-back reads.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, AW'(k), DW'(k * 3), 2'b11, 0, '0);
    end
    drain();
    valid_cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, '0, '0, '0, 1, AW'(k));
      push(DW'(k * 3));
    end
    drain();
    check("stream_valid_pulses", 32'(valid_cnt), 32'(DEPTH));

    // Same-cycle same-address collision, then a plain follow-up read.
    drive(1, 8'h20, 16'h1234, 2'b11, 0, '0);
    drive(1, 8'h20, 16'hFFFF, 2'b01, 1, 8'h20);
    push(COLL_EXP);
    drive(0, '0, '0, '0, 1, 8'h20);
    push(16'h12FF);
    drain();

    // Reset in the middle of a read stream.
    for (int k = 0; k < 12; k++) begin
      drive(0, '0, '0, '0, 1, AW'(k));
      push(DW'(k * 3));
    end
    @(negedge clk);
    assert_rst();
    release_rst(0);
    sweep_zero();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_1w1r_masked.md
# ram_1w1r_masked

Parametrised single-clock 1-write/1-read synchronous RAM: the next generation of the NCO lookup/sample store. It adds per-lane write masking, a hardware clear sequence after reset, a read-valid strobe and optional read-during-write forwarding. Phase-to-amplitude tables and sample buffers use it in place of the fixed 256x16 two-clock macro model.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits; must be an integer multiple of WMASK_WIDTH.
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH (derived, not overridable).
- WMASK_WIDTH, 2, number of write lanes; lane width = DATA_WIDTH / WMASK_WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- csb0  in  1  write-port select, active low.
- wmask0  in  WMASK_WIDTH  write lane enables, bit i covers lane i.
- addr0  in  ADDR_WIDTH  write address.
- din0  in  DATA_WIDTH  write data.
- csb1  in  1  read-port select, active low.
- addr1  in  ADDR_WIDTH  read address.
- dout1  out  DATA_WIDTH  read data, registered.
- dout1_valid  out  1  one-cycle strobe: dout1 updated this cycle.
- busy  out  1  high while the clear sequence runs; port requests are ignored.

## Operation
- FSM states: INIT, READY.
- rst asserted: FSM to INIT, clear pointer = 0, dout1 = 0, dout1_valid = 0, busy = 1. Memory contents are not reset asynchronously.
- INIT:
  - Each posedge writes all-zero to mem[clear pointer] and increments the pointer.
  - On the edge that writes address RAM_DEPTH-1, the FSM moves to READY and busy drops to 0.
  - The sequence takes exactly RAM_DEPTH cycles.
  - csb0 and csb1 requests are dropped, not queued. dout1 holds and dout1_valid stays 0.
- READY write: csb0=0 at a posedge updates every lane i with wmask0[i]=1 to din0 lane i. Lanes with a 0 mask bit keep their value. wmask0 all-zero is a legal no-op.
- READY read:
  - csb1=0 at posedge N loads dout1 with mem[addr1] and sets dout1_valid=1 after edge N.
  - csb1=1: dout1 holds its last value and dout1_valid=0.
- Write then read of the same address on the next cycle returns the new data.
- Same-cycle write and read of the same address: behaviour is set by the macro (see Configuration). Different addresses are independent.
- Reset mid-operation (in INIT or READY): restarts INIT at address 0 and clears the whole array again. In-flight reads are discarded.
- Addresses wrap naturally; every ADDR_WIDTH value is valid.

## Timing
- Write latency: data visible to any read sampled one edge after the write edge.
- Read latency: 1 cycle from the request edge to dout1/dout1_valid.
- Throughput: one write and one read per cycle, sustained.
- Post-reset: busy is high for RAM_DEPTH cycles after rst deasserts. The first accepted request is at the first edge with busy=0.
- Output reset values: dout1 = 0, dout1_valid = 0, busy = 1.

## Configuration
- RAM_BYPASS_EN defined: a same-cycle, same-address write and read returns the merged word on dout1. Masked lanes carry din0; unmasked lanes carry the old content.
- RAM_BYPASS_EN undefined: the same collision returns the old content (read-before-write). The write still completes.

## Test plan
- Reset/clear: preload garbage via hierarchical force, pulse rst, count cycles -> busy high exactly 256 cycles; every address then reads 0x0000 with dout1_valid=1.
- Masked write: write 0xAAAA mask 2'b11 to addr 0x10, then 0x5555 mask 2'b01 -> read 0x10 returns 0xAA55.
- Streaming: write addr k = k*3 for k=0..255 back-to-back, then read 0..255 back-to-back -> 256 consecutive dout1_valid pulses; data k*3 (mod 2^16) at one-cycle latency.
- Collision: mem[0x20]=0x1234; same cycle write 0xFFFF mask 2'b01 and read 0x20 -> 0x12FF with RAM_BYPASS_EN, 0x1234 without; a following read returns 0x12FF in both builds.
- Busy drop: issue a write of 0xBEEF to 0x05 and a read during INIT -> no dout1_valid; after busy falls, 0x05 reads 0x0000.
- Mid-run reset: assert rst during a read stream in READY -> dout1=0 and dout1_valid=0 immediately (asynchronous); busy high for 256 cycles; previously written data reads 0.
